ioctl_sdram_loader: RTL and testbench

Parametrised ROM download engine between `data_io` and the multi-port `sdram` controller. It captures `ioctl` byte writes for one selected download index and buffers them in a small FIFO. It merges adjacent even/odd bytes into single 16-bit word writes and drives a toggle req/ack handshake on a configurable set of SDRAM ports, waiting for every targeted port to acknowledge. It also produces the `rom_loaded` qualifier used by the core's reset generation.

---
 rtl/ioctl_sdram_loader.sv | 177 +++++++++++++++++
 tb/tb_ioctl_sdram_loader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_sdram_loader.sv
// ROM download engine: captures ioctl bytes for one index into a small FIFO and
// writes them to one or more SDRAM ports over a toggle req/ack handshake.
module ioctl_sdram_loader #(
  parameter int         PORTS      = 2,
  parameter logic [7:0] INDEX      = 8'd0,
  parameter int         FIFO_DEPTH = 4,
  parameter bit         PACK       = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  input  logic [PORTS-1:0] port_mask,
  output logic [PORTS-1:0] port_req,
  input  logic [PORTS-1:0] port_ack,
  output logic [22:0]      port_a,
  output logic [1:0]       port_ds,
  output logic [15:0]      port_d,
  output logic             port_we,
  output logic             busy,
  output logic             rom_loaded,
  output logic             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, STAGE = 2'd1, ISSUE = 2'd2, WAIT = 2'd3} state_t;

  state_t           state_r;
  logic [31:0]      fifo_mem_r [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             wr_last_r;
  logic             dl_last_r;
  logic             armed_r;
  logic [22:0]      stage_hi_r;
  logic [7:0]       stage_data_r;
  logic [PORTS-1:0] req_r;
  logic [PORTS-1:0] mask_r;
  logic [22:0]      a_r;
  logic [1:0]       ds_r;
  logic [15:0]      d_r;
  logic             we_r;
  logic             busy_r;
  logic             loaded_r;
  logic             overflow_r;

  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic [23:0]      head_addr_s;
  logic [7:0]       head_data_s;
  logic             adjacent_s;
  logic             push_req_s;
  logic             push_s;
  logic             pop_s;
  logic             unused_s;

  assign unused_s = ioctl_addr[24];

  // FIFO status, head-of-queue view and push/pop decisions
  always_comb begin
    fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    head_addr_s  = fifo_mem_r[rd_ptr_r[AW-1:0]][31:8];
    head_data_s  = fifo_mem_r[rd_ptr_r[AW-1:0]][7:0];
    adjacent_s   = (head_addr_s == {stage_hi_r, 1'b1});
    push_req_s   = ioctl_wr && !wr_last_r && ioctl_download && (ioctl_index == INDEX);
    if (state_r == IDLE) begin
      pop_s = !fifo_empty_s;
    end else if (state_r == STAGE) begin
      // a non-adjacent head stays queued and becomes the next IDLE candidate
      pop_s = !fifo_empty_s && adjacent_s;
    end else begin
      pop_s = 1'b0;
    end
    push_s = push_req_s && (!fifo_full_s || pop_s);
  end

  // FIFO storage
  always_ff @(posedge clk_sys) begin
    if (push_s) fifo_mem_r[wr_ptr_r[AW-1:0]] <= {ioctl_addr[23:0], ioctl_dout};
  end

  // Capture edge detect, FIFO pointers and status flags
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_last_r  <= 1'b0;
      dl_last_r  <= 1'b0;
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      we_r       <= 1'b0;
      loaded_r   <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      wr_last_r <= ioctl_wr;
      dl_last_r <= ioctl_download;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      if (push_req_s && !push_s) overflow_r <= 1'b1;
      busy_r <= push_s || !fifo_empty_s || (state_r != IDLE);
      if (push_s) we_r <= 1'b1;
      else if (!ioctl_download && fifo_empty_s && (state_r == IDLE)) we_r <= 1'b0;
      if (ioctl_download && !dl_last_r && (ioctl_index == INDEX)) begin
        loaded_r <= 1'b0;
        armed_r  <= 1'b1;
      end else if (armed_r && !ioctl_download && fifo_empty_s && (state_r == IDLE)) begin
        loaded_r <= 1'b1;
        armed_r  <= 1'b0;
      end
    end
  end

  // Write-forming and handshake state machine
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r      <= IDLE;
      stage_hi_r   <= 23'd0;
      stage_data_r <= 8'd0;
      req_r        <= {PORTS{1'b0}};
      mask_r       <= {PORTS{1'b0}};
      a_r          <= 23'd0;
      ds_r         <= 2'b00;
      d_r          <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            a_r <= head_addr_s[23:1];
            if (PACK && !head_addr_s[0]) begin
              stage_hi_r   <= head_addr_s[23:1];
              stage_data_r <= head_data_s;
              state_r      <= STAGE;
            end else begin
              ds_r    <= head_addr_s[0] ? 2'b10 : 2'b01;
              d_r     <= {head_data_s, head_data_s};
              state_r <= ISSUE;
            end
          end
        end
        STAGE: begin
          if (!fifo_empty_s && adjacent_s) begin
            ds_r    <= 2'b11;
            d_r     <= {head_data_s, stage_data_r};
            state_r <= ISSUE;
          end else if (!fifo_empty_s || !ioctl_download) begin
            ds_r    <= 2'b01;
            d_r     <= {stage_data_r, stage_data_r};
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          mask_r  <= port_mask;
          req_r   <= req_r ^ port_mask;
          state_r <= (port_mask == {PORTS{1'b0}}) ? IDLE : WAIT;
        end
        WAIT: begin
          if (((port_ack ^ req_r) & mask_r) == {PORTS{1'b0}}) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign port_req   = req_r;
  assign port_a     = a_r;
  assign port_ds    = ds_r;
  assign port_d     = d_r;
  assign port_we    = we_r;
  assign busy       = busy_r;
  assign rom_loaded = loaded_r;
  assign overflow   = overflow_r;
endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Scoreboard bench: a packing and a non-packing loader share one ioctl stream;
// each SDRAM write (req toggle) is compared against the expected-write queue.
module tb_ioctl_sdram_loader;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [1:0]  port_mask;

  logic [1:0]  req_a  [2];
  logic [1:0]  ack_a  [2];
  logic [22:0] a_a    [2];
  logic [1:0]  ds_a   [2];
  logic [15:0] d_a    [2];
  logic [1:0]  we_a;
  logic [1:0]  busy_a;
  logic [1:0]  loaded_a;
  logic [1:0]  ovf_a;

  logic [42:0] q0 [$];
  logic [42:0] q1 [$];
  logic [1:0]  prev_req [2];
  int          n_tog [2];
  int          last_tog_cyc [2];
  int          lat [2];
  int          ack_cnt [2][2];
  int          cyc = 0;
  int          strobe_cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk_sys = ~clk_sys;

  ioctl_sdram_loader #(.PORTS(2), .INDEX(8'd0), .FIFO_DEPTH(4), .PACK(1'b1)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .port_mask(port_mask), .port_req(req_a[0]),
    .port_ack(ack_a[0]), .port_a(a_a[0]), .port_ds(ds_a[0]), .port_d(d_a[0]),
    .port_we(we_a[0]), .busy(busy_a[0]), .rom_loaded(loaded_a[0]), .overflow(ovf_a[0]));

  ioctl_sdram_loader #(.PORTS(2), .INDEX(8'd0), .FIFO_DEPTH(4), .PACK(1'b0)) dut_np (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .port_mask(port_mask), .port_req(req_a[1]),
    .port_ack(ack_a[1]), .port_a(a_a[1]), .port_ds(ds_a[1]), .port_d(d_a[1]),
    .port_we(we_a[1]), .busy(busy_a[1]), .rom_loaded(loaded_a[1]), .overflow(ovf_a[1]));

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input int k, input logic [22:0] a, input logic [1:0] ds,
                           input logic [15:0] d, input logic [1:0] m);
    if (k == 0) q0.push_back({a, ds, d, m});
    else q1.push_back({a, ds, d, m});
  endtask

  task automatic expect_both(input logic [22:0] a, input logic [1:0] ds,
                             input logic [15:0] d, input logic [1:0] m);
    expect_wr(0, a, ds, d, m);
    expect_wr(1, a, ds, d, m);
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input int hold);
    @(posedge clk_sys); #1;
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    strobe_cyc = cyc + 1;
    repeat (hold) @(posedge clk_sys);
    #1 ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_a != 2'b00 || q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check_val(tag, (n < 2000), 1);
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  always @(posedge clk_sys) cyc = cyc + 1;

  // SDRAM side: each port echoes req onto ack after lat[i] cycles
  always @(negedge clk_sys) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          ack_a[k][i] = 1'b0;
          ack_cnt[k][i] = 0;
        end else if (ack_a[k][i] != req_a[k][i]) begin
          ack_cnt[k][i]++;
          if (ack_cnt[k][i] >= lat[i]) begin
            ack_a[k][i] = req_a[k][i];
            ack_cnt[k][i] = 0;
          end
        end else begin
          ack_cnt[k][i] = 0;
        end
      end
    end
  end

  // Write monitor: every req toggle is one write, checked against the queue head
  always @(negedge clk_sys) begin
    logic [42:0] got;
    logic [42:0] exp;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        prev_req[k] = 2'b00;
      end else if (req_a[k] != prev_req[k]) begin
        got = {a_a[k], ds_a[k], d_a[k], req_a[k] ^ prev_req[k]};
        exp = 43'd0;
        if (k == 0 && q0.size() > 0) exp = q0.pop_front();
        if (k == 1 && q1.size() > 0) exp = q1.pop_front();
        check_val((k == 0) ? "wr_pack" : "wr_nopack", got, exp);
        n_tog[k]++;
        last_tog_cyc[k] = cyc;
        prev_req[k] = req_a[k];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n1;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0; port_mask = 2'b11;
    lat[0] = 3; lat[1] = 3;
    ack_a[0] = 2'b00; ack_a[1] = 2'b00;
    prev_req[0] = 2'b00; prev_req[1] = 2'b00;
    n_tog[0] = 0; n_tog[1] = 0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;

    check_val("rst_req", req_a[0], 2'b00);
    check_val("rst_busy", busy_a, 2'b00);
    check_val("rst_loaded", loaded_a, 2'b00);
    check_val("rst_ovf", ovf_a, 2'b00);
    check_val("rst_a", a_a[0], 23'd0);
    check_val("rst_we", we_a, 2'b00);

    // single odd byte
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    expect_both(23'h000001, 2'b10, 16'hA5A5, 2'b11);
    send_byte(25'h000003, 8'hA5, 1);
    check_val("we_active", we_a, 2'b11);
    wait_idle("idle_single");
    check_val("lat_odd_pack", last_tog_cyc[0] - strobe_cyc, 2);
    check_val("lat_odd_nopack", last_tog_cyc[1] - strobe_cyc, 2);

    // even+odd pair
    expect_wr(0, 23'h000008, 2'b11, 16'h2211, 2'b11);
    expect_wr(1, 23'h000008, 2'b01, 16'h1111, 2'b11);
    expect_wr(1, 23'h000008, 2'b10, 16'h2222, 2'b11);
    send_byte(25'h000010, 8'h11, 1);
    send_byte(25'h000011, 8'h22, 1);
    wait_idle("idle_pair");

    // even byte held in staging until the download ends
    expect_both(23'h000010, 2'b01, 16'h3333, 2'b11);
    n0 = n_tog[0];
    send_byte(25'h000020, 8'h33, 1);
    repeat (4) @(posedge clk_sys);
    #1;
    check_val("stage_hold", n_tog[0], n0);
    check_val("stage_busy", busy_a[0], 1'b1);
    ioctl_download = 1'b0;
    wait_idle("idle_flush");
    check_val("loaded_set", loaded_a, 2'b11);
    check_val("we_idle", we_a, 2'b00);

    // other index is ignored
    n0 = n_tog[0]; n1 = n_tog[1];
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    send_byte(25'h000031, 8'h44, 1);
    ioctl_download = 1'b0;
    wait_idle("idle_idx1");
    check_val("idx1_nowr_pack", n_tog[0], n0);
    check_val("idx1_nowr_nopack", n_tog[1], n1);
    check_val("idx1_loaded_kept", loaded_a, 2'b11);

    // overflow while port 1 withholds its ack
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check_val("loaded_clr", loaded_a, 2'b00);
    lat[1] = 50;
    for (int j = 0; j < 5; j++)
      expect_both(23'h000020 + 23'(j), 2'b10, {2{8'hC0 + 8'(j)}}, 2'b11);
    for (int j = 0; j < 6; j++)
      send_byte(25'h000041 + 25'(2 * j), 8'hC0 + 8'(j), 1);
    check_val("ovf_set", ovf_a, 2'b11);
    check_val("queued_pack", q0.size(), 4);
    check_val("queued_nopack", q1.size(), 4);
    lat[1] = 3;
    wait_idle("idle_ovf");
    check_val("ovf_sticky", ovf_a, 2'b11);

    // held strobe, then a single-port mask
    n0 = n_tog[0];
    expect_both(23'h000028, 2'b10, 16'h7777, 2'b11);
    send_byte(25'h000051, 8'h77, 5);
    wait_idle("idle_held");
    check_val("held_one_wr", n_tog[0], n0 + 1);
    port_mask = 2'b01;
    expect_both(23'h000029, 2'b10, 16'h5A5A, 2'b01);
    send_byte(25'h000053, 8'h5A, 1);
    wait_idle("idle_mask");
    port_mask = 2'b11;

    // reset in the middle of a handshake
    lat[0] = 40; lat[1] = 40;
    expect_both(23'h000030, 2'b10, 16'h8888, 2'b11);
    send_byte(25'h000061, 8'h88, 1);
    repeat (5) @(posedge clk_sys);
    #1;
    check_val("wait_issued", q0.size(), 0);
    check_val("wait_busy", busy_a, 2'b11);
    ioctl_download = 1'b0;
    reset = 1'b1;
    @(posedge clk_sys);
    #1 reset = 1'b0;
    check_val("rst_wait_req_pack", req_a[0], 2'b00);
    check_val("rst_wait_req_nopack", req_a[1], 2'b00);
    check_val("rst_wait_busy", busy_a, 2'b00);
    check_val("rst_wait_we", we_a, 2'b00);
    lat[0] = 3; lat[1] = 3;

    // other index cannot set rom_loaded
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    send_byte(25'h000035, 8'h66, 1);
    ioctl_download = 1'b0;
    wait_idle("idle_idx1b");
    check_val("idx1_noload", loaded_a, 2'b00);

    // fresh download after reset
    n0 = n_tog[0];
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    expect_both(23'h000038, 2'b10, 16'h9999, 2'b11);
    send_byte(25'h000071, 8'h99, 1);
    ioctl_download = 1'b0;
    wait_idle("idle_after_rst");
    check_val("after_rst_one_wr", n_tog[0], n0 + 1);
    check_val("after_rst_loaded", loaded_a, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
